// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 5-stage pipelined CPU datapath.
//   - Default datapath / register-address / ALUCtrl widths.
//   - ALUCtrl operation encodings understood by the ALU.
//   - Forward-select codes used by the operand forwarding muxes.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RA_W_DEF   = 5;
  localparam int CTRL_W_DEF = 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_MUL = 3'b011,
    ALU_SUB = 3'b110
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: operand forwarding for one ALU source register.
// Compares the stage's registered source address against the EX/MEM and
// MEM/WB destination registers and picks the youngest producer.
// Ports:
//   addr_i        registered source register address
//   reg_data_i    registered register-file read data
//   exmem_we_i/exmem_addr_i/exmem_data_i  EX/MEM write-back candidate
//   memwb_we_i/memwb_addr_i/memwb_data_i  MEM/WB write-back candidate
//   data_o        forwarded operand value
module fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF
) (
  input  logic [RA_W-1:0]   addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              exmem_we_i,
  input  logic [RA_W-1:0]   exmem_addr_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_we_i,
  input  logic [RA_W-1:0]   memwb_addr_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [DATA_W-1:0] data_o
);

  fwd_sel_e sel;

  // Register 0 is hard-wired to zero, so a claimed write to it is never
  // forwarded. EX/MEM is younger than MEM/WB and therefore wins ties.
  always_comb begin
    sel = FWD_REG;
    if (addr_i != '0 && exmem_we_i && exmem_addr_i == addr_i) begin
      sel = FWD_EXMEM;
    end else if (addr_i != '0 && memwb_we_i && memwb_addr_i == addr_i) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      FWD_EXMEM: data_o = exmem_data_i;
      FWD_MEMWB: data_o = memwb_data_i;
      default:   data_o = reg_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Registers decoded operands, immediate, register addresses, ALUCtrl and
// MEM/WB control; resolves forwarding for both ALU operands; detects
// load-use hazards and inserts its own bubble for them.
// Ports:
//   clk_i, rst_i (async, active-low)
//   stall_i  hold every stage register
//   flush_i  replace the captured instruction with a bubble
//   valid_i, RSdata_i, RTdata_i, imm_i, RS/RT/RDaddr_i, ID control  ID side
//   EXMEM_* / MEMWB_*  forwarding sources
//   data1_o, data2_o, ALUCtrl_o, store_data_o  ALU / store operands
//   WBaddr_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, valid_o
//   load_use_o  upstream must hold PC and IF/ID this cycle
//
// Stage handshake: there is no ready. valid_o marks a real instruction in
// the stage; a bubble has valid_o=0 and all side-effect controls
// (RegWrite/MemToReg/MemRead/MemWrite) at 0. Per edge the priority is
// flush_i > stall_i > load-use bubble > capture. On a load-use cycle the
// upstream stages hold, so the same ID instruction is offered again and
// captured on the following edge.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RA_W   = RA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [RA_W-1:0]   RSaddr_i,
  input  logic [RA_W-1:0]   RTaddr_i,
  input  logic [RA_W-1:0]   RDaddr_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [CTRL_W-1:0] ALUCtrl_i,
  input  logic              EXMEM_RegWrite_i,
  input  logic [RA_W-1:0]   EXMEM_RDaddr_i,
  input  logic [DATA_W-1:0] EXMEM_data_i,
  input  logic              MEMWB_RegWrite_i,
  input  logic [RA_W-1:0]   MEMWB_RDaddr_i,
  input  logic [DATA_W-1:0] MEMWB_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [RA_W-1:0]   WBaddr_o,
  output logic              RegWrite_o,
  output logic              MemToReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              valid_o,
  output logic              load_use_o
);

  logic              valid_q,    valid_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              memread_q,  memread_d;
  logic              memwrite_q, memwrite_d;
  logic              alusrc_q,   alusrc_d;
  logic [CTRL_W-1:0] aluctrl_q,  aluctrl_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [RA_W-1:0]   rs_addr_q,  rs_addr_d;
  logic [RA_W-1:0]   rt_addr_q,  rt_addr_d;
  logic [RA_W-1:0]   wb_addr_q,  wb_addr_d;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in the stage whose destination is read by the valid ID
  // instruction. The bubble it causes clears memread_q, so this is a
  // single-cycle pulse per load-use pair.
  assign load_use_o = valid_q & memread_q & (wb_addr_q != '0) &
                      ((wb_addr_q == RSaddr_i) | (wb_addr_q == RTaddr_i)) &
                      valid_i;

  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    aluctrl_d  = aluctrl_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    wb_addr_d  = wb_addr_q;
    if (flush_i || (!stall_i && load_use_o)) begin
      // Bubble: only side-effect controls are killed; data may go stale.
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end else if (!stall_i) begin
      valid_d    = valid_i;
      regwrite_d = RegWrite_i;
      memtoreg_d = MemToReg_i;
      memread_d  = MemRead_i;
      memwrite_d = MemWrite_i;
      alusrc_d   = ALUSrc_i;
      aluctrl_d  = ALUCtrl_i;
      rs_data_d  = RSdata_i;
      rt_data_d  = RTdata_i;
      imm_d      = imm_i;
      rs_addr_d  = RSaddr_i;
      rt_addr_d  = RTaddr_i;
      wb_addr_d  = RegDst_i ? RDaddr_i : RTaddr_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluctrl_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      wb_addr_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      aluctrl_q  <= aluctrl_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      wb_addr_q  <= wb_addr_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rs (
    .addr_i       (rs_addr_q),
    .reg_data_i   (rs_data_q),
    .exmem_we_i   (EXMEM_RegWrite_i),
    .exmem_addr_i (EXMEM_RDaddr_i),
    .exmem_data_i (EXMEM_data_i),
    .memwb_we_i   (MEMWB_RegWrite_i),
    .memwb_addr_i (MEMWB_RDaddr_i),
    .memwb_data_i (MEMWB_data_i),
    .data_o       (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_rt (
    .addr_i       (rt_addr_q),
    .reg_data_i   (rt_data_q),
    .exmem_we_i   (EXMEM_RegWrite_i),
    .exmem_addr_i (EXMEM_RDaddr_i),
    .exmem_data_i (EXMEM_data_i),
    .memwb_we_i   (MEMWB_RegWrite_i),
    .memwb_addr_i (MEMWB_RDaddr_i),
    .memwb_data_i (MEMWB_data_i),
    .data_o       (rt_fwd)
  );

  assign data1_o      = rs_fwd;
  assign store_data_o = rt_fwd;
  assign data2_o      = alusrc_q ? imm_q : rt_fwd;
  assign ALUCtrl_o    = aluctrl_q;
  assign WBaddr_o     = wb_addr_q;
  assign RegWrite_o   = regwrite_q;
  assign MemToReg_o   = memtoreg_q;
  assign MemRead_o    = memread_q;
  assign MemWrite_o   = memwrite_q;
  assign valid_o      = valid_q;

endmodule
